// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
//   fetch_state_e : fetch FSM states (issue / wait / hold / drop-stale)
//   PC_INC        : byte stride between sequential instructions
//   DEF_RESET_PC  : default reset program counter
package fetch_pkg;
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DROP} fetch_state_e;
  localparam int          PC_INC       = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus.
//   master (fetch side): drives imem_req_valid/imem_addr, receives ready and response
//   slave  (memory side): the mirror image
interface fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;

  modport master (output imem_req_valid, imem_addr,
                  input  imem_req_ready, imem_rsp_valid, imem_rsp_data);
  modport slave  (input  imem_req_valid, imem_addr,
                  output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched (instr, pc) pair that arrives while
// the instruction register is still occupied.
//   load/in_*  : capture a new entry
//   unload     : entry moved out this cycle
//   clear      : drop the entry (redirect); wins over load/unload
//   valid/instr/pc : current entry
module fetch_skid #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);
  always_ff @(posedge clk) begin
    if (rst || clear)  valid <= 1'b0;
    else if (load)     valid <= 1'b1;
    else if (unload)   valid <= 1'b0;
    // payload needs no reset: it is only observed while valid
    if (load) begin
      instr <= in_instr;
      pc    <= in_pc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, keeps at most one memory request
// in flight, presents instructions to decode through a valid/stall register
// and retargets on a branch-resolution jump (pulsing flush the next cycle).
//   clk, rst          : clock, synchronous active-high reset
//   stall             : decode cannot accept this cycle
//   jump, jump_target : redirect request and target (low two bits ignored)
//   imem              : instruction-memory bus (master side)
//   if_valid/instr/pc : instruction register towards decode
//   flush             : one-cycle pulse the cycle after a jump
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  fetch_if.master            imem,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               flush
);
  fetch_state_e       state, nxt;
  logic [ADDR_W-1:0]  pc, req_pc;
  logic               req_valid;
  logic               hs, rsp, ir_free;
  logic               ir_load, hold_load, hold_unload;
  logic               hold_valid;
  logic [INSTR_W-1:0] hold_instr;
  logic [ADDR_W-1:0]  hold_pc;

  assign hs          = req_valid && imem.imem_req_ready;
  assign rsp         = imem.imem_rsp_valid;
  assign ir_free     = !if_valid || !stall;
  assign ir_load     = (state == ST_WAIT) && rsp && ir_free && !jump;
  assign hold_load   = (state == ST_WAIT) && rsp && !ir_free && !jump;
  assign hold_unload = hold_valid && ir_free && !jump;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_REQ;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_REQ:  if (jump)     nxt = hs ? ST_DROP : ST_REQ;
               else if (hs)  nxt = ST_WAIT;
      ST_WAIT: if (rsp)      nxt = (jump || ir_free) ? ST_REQ : ST_HOLD;
               else if (jump) nxt = ST_DROP;
      ST_HOLD: if (jump || ir_free) nxt = ST_REQ;
      // a stale response frees the bus even if another jump lands with it
      ST_DROP: if (rsp)      nxt = ST_REQ;
      default:               nxt = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      req_pc    <= '0;
      req_valid <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= '0;
      if_pc     <= '0;
      flush     <= 1'b0;
    end else begin
      // request valid is a pure function of the next state, so it is low
      // for exactly the first cycle after reset
      req_valid <= (nxt == ST_REQ);
      flush     <= jump;
      if (jump) pc <= jump_target & ~ADDR_W'(3);
      else if (hs) begin
        pc     <= pc + ADDR_W'(PC_INC);
        req_pc <= pc;
      end
      if (jump)             if_valid <= 1'b0;
      else if (ir_load) begin
        if_valid <= 1'b1;
        if_instr <= imem.imem_rsp_data;
        if_pc    <= req_pc;
      end else if (hold_unload) begin
        if_valid <= 1'b1;
        if_instr <= hold_instr;
        if_pc    <= hold_pc;
      end else if (!stall)  if_valid <= 1'b0;
    end
  end

  fetch_skid #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .unload   (hold_unload),
    .clear    (jump),
    .in_instr (imem.imem_rsp_data),
    .in_pc    (req_pc),
    .valid    (hold_valid),
    .instr    (hold_instr),
    .pc       (hold_pc)
  );
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction
  function automatic logic [31:0] memfn2(input logic [7:0] a);
    return {24'hC0FFEE, a};
  endfunction

  // ---------------- DUT 1: 32-bit, RESET_PC = 0 ----------------
  logic        rst = 1'b1, stall = 1'b0, jump = 1'b0, ready = 1'b1;
  logic [31:0] jump_target = '0;
  logic        ifv, flush;
  logic [31:0] ifi, ifp;
  int          lat = 1;
  logic        m_rsp;
  logic [31:0] m_data, m_addr;
  int          m_cnt;
  logic [31:0] hs_log[$];

  fetch_if #(.ADDR_W(32), .INSTR_W(32)) m1();
  assign m1.imem_req_ready = ready;
  assign m1.imem_rsp_valid = m_rsp;
  assign m1.imem_rsp_data  = m_data;

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jump_target(jump_target),
    .imem(m1.master), .if_valid(ifv), .if_instr(ifi), .if_pc(ifp), .flush(flush));

  // memory: response exactly lat cycles after acceptance
  always @(posedge clk) begin
    if (rst) begin
      m_rsp <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_rsp <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin m_rsp <= 1'b1; m_data <= memfn(m_addr); end
      end
      if (m1.imem_req_valid && m1.imem_req_ready) begin
        hs_log.push_back(m1.imem_addr);
        m_addr <= m1.imem_addr;
        if (lat <= 1) begin m_rsp <= 1'b1; m_data <= memfn(m1.imem_addr); end
        else m_cnt <= lat - 1;
      end
    end
  end

  // never request while a response is still owed
  always @(negedge clk)
    if (!rst && m1.imem_req_valid) chk("one_outstanding", (m_cnt != 0) || m_rsp, 1'b0);

  // ---------------- DUT 2: 8-bit, RESET_PC = 0xF8 ----------------
  logic        rst2 = 1'b1, stall2 = 1'b0, jump2 = 1'b0;
  logic [7:0]  jump_target2 = '0;
  logic        ifv2, flush2, m2_rsp;
  logic [31:0] ifi2, m2_data;
  logic [7:0]  ifp2;
  logic [7:0]  hs2_log[$];

  fetch_if #(.ADDR_W(8), .INSTR_W(32)) m2();
  assign m2.imem_req_ready = 1'b1;
  assign m2.imem_rsp_valid = m2_rsp;
  assign m2.imem_rsp_data  = m2_data;

  fetch_unit #(.ADDR_W(8), .INSTR_W(32), .RESET_PC(8'hF8)) dut2 (
    .clk(clk), .rst(rst2), .stall(stall2), .jump(jump2), .jump_target(jump_target2),
    .imem(m2.master), .if_valid(ifv2), .if_instr(ifi2), .if_pc(ifp2), .flush(flush2));

  always @(posedge clk) begin
    if (rst2) m2_rsp <= 1'b0;
    else begin
      m2_rsp <= 1'b0;
      if (m2.imem_req_valid) begin
        hs2_log.push_back(m2.imem_addr);
        m2_rsp  <= 1'b1;
        m2_data <= memfn2(m2.imem_addr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // wait for if_valid; report cycles waited, first request address, flushes seen
  task automatic wait_ifv(input int max, output int n, output logic [31:0] first_addr,
                          output int nfl);
    n = 0; first_addr = '1; nfl = 0;
    do begin
      @(negedge clk);
      n++;
      if (flush) nfl++;
      if (m1.imem_req_valid && first_addr == 32'hFFFF_FFFF) first_addr = m1.imem_addr;
    end while (!ifv && n < max);
    chk("ifv_seen", ifv, 1'b1);
  endtask

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl[15];

  int          n, nfl;
  logic [31:0] fa;

  initial begin
    // per-cycle after reset release, L=1, always ready
    tbl[0]  = '{0, 0, 32'h00, 0, 32'h00};
    tbl[1]  = '{0, 1, 32'h00, 0, 32'h00};
    tbl[2]  = '{0, 0, 32'h00, 0, 32'h00};
    tbl[3]  = '{0, 1, 32'h04, 1, 32'h00};
    tbl[4]  = '{0, 0, 32'h00, 0, 32'h00};
    tbl[5]  = '{0, 1, 32'h08, 1, 32'h04};
    tbl[6]  = '{0, 0, 32'h00, 0, 32'h00};
    tbl[7]  = '{1, 1, 32'h0C, 1, 32'h08};
    tbl[8]  = '{1, 0, 32'h00, 1, 32'h08};
    tbl[9]  = '{1, 0, 32'h00, 1, 32'h08};
    tbl[10] = '{1, 0, 32'h00, 1, 32'h08};
    tbl[11] = '{0, 0, 32'h00, 1, 32'h08};
    tbl[12] = '{0, 1, 32'h10, 1, 32'h0C};
    tbl[13] = '{0, 0, 32'h00, 0, 32'h00};
    tbl[14] = '{0, 1, 32'h14, 1, 32'h10};

    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("t%0d_req_valid", i), m1.imem_req_valid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("t%0d_addr", i), m1.imem_addr, tbl[i].addr);
      chk($sformatf("t%0d_if_valid", i), ifv, tbl[i].ifv);
      chk($sformatf("t%0d_flush", i), flush, 1'b0);
      if (tbl[i].ifv) begin
        chk($sformatf("t%0d_if_pc", i), ifp, tbl[i].pc);
        chk($sformatf("t%0d_if_instr", i), ifi, memfn(tbl[i].pc));
      end
      if (i == 0) begin
        chk("rst_if_instr", ifi, 32'h0);
        chk("rst_if_pc", ifp, 32'h0);
        rst = 1'b0;
      end
      stall = tbl[i].stall;
    end
    lat = 3;

    // jump while waiting on a slow response
    @(negedge clk);
    chk("a_wait_ifv", ifv, 1'b0);
    jump = 1'b1; jump_target = 32'h103;
    @(negedge clk);
    chk("a_flush", flush, 1'b1);
    chk("a_ifv_after_jump", ifv, 1'b0);
    jump = 1'b0;
    wait_ifv(30, n, fa, nfl);
    chk("a_first_addr", fa, 32'h100);
    chk("a_if_pc", ifp, 32'h100);
    chk("a_if_instr", ifi, memfn(32'h100));
    chk("a_extra_flush", nfl, 0);

    // jump in the same cycle as the response
    n = 0;
    do begin @(negedge clk); n++; end while (!m_rsp && n < 10);
    chk("b_rsp_seen", m_rsp, 1'b1);
    jump = 1'b1; jump_target = 32'h200;
    @(negedge clk);
    chk("b_flush", flush, 1'b1);
    chk("b_ifv", ifv, 1'b0);
    chk("b_req_valid", m1.imem_req_valid, 1'b1);
    chk("b_addr", m1.imem_addr, 32'h200);
    jump = 1'b0;
    wait_ifv(20, n, fa, nfl);
    chk("b_latency", n, 4);
    chk("b_if_pc", ifp, 32'h200);

    // memory not ready for 5 cycles, jump in the middle
    hs_log.delete();
    lat = 1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      ready = 1'b0;
      if (i == 3) begin
        chk("c_flush", flush, 1'b1);
        chk("c_req_valid", m1.imem_req_valid, 1'b1);
        chk("c_addr", m1.imem_addr, 32'h40);
        jump = 1'b0;
      end
      if (i == 2) begin jump = 1'b1; jump_target = 32'h40; end
    end
    @(negedge clk);
    ready = 1'b1;
    wait_ifv(20, n, fa, nfl);
    chk("c_hs_count", hs_log.size() >= 1, 1'b1);
    if (hs_log.size() >= 1) chk("c_first_hs", hs_log[0], 32'h40);
    chk("c_if_pc", ifp, 32'h40);

    // 8-bit PC wrap and reset while waiting
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 7) begin
        chk("w_ifv", ifv2, 1'b1);
        chk("w_if_pc", ifp2, 8'h00);
        chk("w_if_instr", ifi2, memfn2(8'h00));
      end
    end
    chk("w_wait_req_valid", m2.imem_req_valid, 1'b0);
    chk("w_wait_rsp", m2_rsp, 1'b1);
    chk("w_hs_count", hs2_log.size() >= 3, 1'b1);
    if (hs2_log.size() >= 3) begin
      chk("w_hs0", hs2_log[0], 8'hF8);
      chk("w_hs1", hs2_log[1], 8'hFC);
      chk("w_hs2", hs2_log[2], 8'h00);
    end
    rst2 = 1'b1;
    @(negedge clk);
    chk("r_req_valid", m2.imem_req_valid, 1'b0);
    chk("r_addr", m2.imem_addr, 8'hF8);
    chk("r_ifv", ifv2, 1'b0);
    chk("r_if_instr", ifi2, 32'h0);
    chk("r_if_pc", ifp2, 8'h0);
    chk("r_flush", flush2, 1'b0);
    rst2 = 1'b0;
    @(negedge clk);
    chk("r_req_valid_after", m2.imem_req_valid, 1'b1);
    chk("r_addr_after", m2.imem_addr, 8'hF8);

    // randomized run against a program-order model: decode must see
    // pc, pc+4, ... restarting at each jump target, with flush after each jump
    rst = 1'b1; stall = 1'b0; jump = 1'b0; ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    begin
      logic [31:0] exp_pc, hp, hi, tgt;
      logic        pj, ph, st, jp;
      int          consumed;
      exp_pc = 32'h0; pj = 1'b0; ph = 1'b0; hp = '0; hi = '0; consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc > 0) @(negedge clk);
        chk("rnd_flush", flush, pj);
        if (pj) chk("rnd_ifv_after_jump", ifv, 1'b0);
        else if (ph) begin
          chk("rnd_hold_ifv", ifv, 1'b1);
          chk("rnd_hold_pc", ifp, hp);
          chk("rnd_hold_instr", ifi, hi);
        end
        st    = ($urandom_range(0, 99) < 30);
        jp    = ($urandom_range(0, 99) < 4);
        tgt   = $urandom;
        ready = ($urandom_range(0, 99) < 75);
        lat   = $urandom_range(1, 3);
        if (jp) exp_pc = tgt & ~32'h3;
        else if (ifv && !st) begin
          chk("rnd_pc", ifp, exp_pc);
          chk("rnd_instr", ifi, memfn(exp_pc));
          exp_pc   = exp_pc + 32'h4;
          consumed++;
        end
        ph = ifv && st && !jp; hp = ifp; hi = ifi; pj = jp;
        stall = st; jump = jp; jump_target = tgt;
      end
      chk("rnd_progress", consumed > 200, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front-end. It owns the program counter and issues one instruction-memory request at a time. It presents fetched instructions to decode with a valid/stall handshake. It is the consumer of the branch-resolution `jump` pulse: on a redirect it retargets the PC, discards in-flight and buffered instructions, and pulses `flush` to the downstream stage.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory byte-address width.
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset; must be word-aligned.

Ports:
- `clk`: input, 1. Single clock; all state changes on the rising edge.
- `rst`: input, 1. Synchronous, active-high reset.
- `stall`: input, 1. Decode cannot accept; holds `if_*` outputs.
- `jump`: input, 1. Single-cycle redirect request from branch logic (already qualified by valid).
- `jump_target`: input, ADDR_W. Redirect address; bits [1:0] ignored (treated as 0).
- `imem_req_valid`: output, 1. Request to instruction memory.
- `imem_req_ready`: input, 1. Memory accepts the request when valid && ready.
- `imem_addr`: output, ADDR_W. Request address.
- `imem_rsp_valid`: input, 1. Response strobe, one cycle per accepted request, ≥1 cycle after acceptance.
- `imem_rsp_data`: input, INSTR_W. Response instruction.
- `if_valid`: output, 1. Instruction register holds a live instruction.
- `if_instr`: output, INSTR_W. Instruction to decode.
- `if_pc`: output, ADDR_W. Address of `if_instr`.
- `flush`: output, 1. One-cycle pulse, registered, the cycle after `jump`.

## Operation
- At most one outstanding memory request. `imem_addr` and `imem_req_valid` are registered.
- Instruction register (IR: `if_valid/if_instr/if_pc`) is consumed when `if_valid && !stall`. IR is "free" when `!if_valid` or consumed this cycle.
- Holding buffer: one entry (instr, pc). Captures a response that arrives while IR is occupied and not consumed.
- States:
  - REQ: `imem_req_valid=1`, `imem_addr=pc`. On handshake: `req_pc<=pc`, `pc<=pc+4`, go to WAIT.
  - WAIT: on `imem_rsp_valid`: if IR free, load IR with (data, req_pc) and go to REQ; else load buffer and go to HOLD.
  - HOLD: `imem_req_valid=0`. When IR is consumed, move buffer to IR and go to REQ.
  - DROP: `imem_req_valid=0`. On `imem_rsp_valid`, discard the response and go to REQ.
- Redirect (`jump=1`) has priority over everything, including `stall`:
  - `pc<=jump_target & ~3`; IR and buffer invalidated (`if_valid<=0`); `flush<=1` next cycle.
  - REQ with handshake this cycle goes to DROP. REQ without handshake stays in REQ, and the next request uses the new PC. The memory samples the address only on handshake.
  - WAIT with `imem_rsp_valid` this cycle discards the response and goes to REQ. WAIT without a response goes to DROP.
  - HOLD goes to REQ.
  - DROP stays in DROP with the PC updated.
- PC arithmetic is modulo 2^ADDR_W: `pc+4` wraps from all-ones-aligned to 0.
- Reset: `pc=RESET_PC`, state=REQ, `imem_req_valid=0` in the reset cycle and 1 from the first cycle after. `if_valid=0`, `if_instr=0`, `if_pc=0`, `flush=0`, buffer empty. Reset mid-transaction abandons any outstanding request. A stale response arriving after reset is ignored only if it lands in REQ. The memory is reset by the same `rst`.

## Timing
- Request accepted at cycle t, response at t+L (L≥1). IR is valid at t+L+1 and the next request is issued at t+L+1.
- Throughput: one instruction per L+1 cycles when not stalled.
- `jump` at cycle t: `if_valid=0` and `flush=1` at t+1. The first request to the target is issued at t+1 if no request is outstanding. Otherwise it is issued the cycle after the stale response.
- `flush` is high for exactly one cycle per `jump`. Back-to-back jumps give back-to-back flush cycles, and the last target wins.

## Structure
- `fetch_pkg` holds:
  - the state enum (REQ, WAIT, HOLD, DROP);
  - the `PC_INC=4` constant;
  - default `RESET_PC`.
- One natural sub-module: `fetch_skid`, the one-entry holding buffer with load/unload/clear. The FSM, PC and IR are inline.

## Test plan
- Reset, memory with L=1 and always ready, `stall=0`: `imem_addr` sequence 0x0, 0x4, 0x8. `if_pc` follows 0x0, 0x4, 0x8 with `if_valid` every 2nd cycle, starting 3 cycles after reset release.
- `stall=1` held for 4 cycles while a response arrives: the response goes into the buffer (HOLD) and no new request is issued. After `stall` drops, IR shows the buffered pc, then fetch resumes at pc+4.
- `jump=1`, target 0x103, while in WAIT with L=3: the stale response is dropped and never appears on `if_*`. `flush` pulses once. Next `imem_addr`=0x100 and `if_pc`=0x100.
- `jump` in the same cycle as `imem_rsp_valid`: the response is discarded, the request to the target is issued next cycle, and `if_valid` stays 0 until the target instruction returns.
- `imem_req_ready=0` for 5 cycles, `jump` to 0x40 in cycle 2: no handshake on the old address. The first accepted address is 0x40.
- PC wrap with ADDR_W=8 and `RESET_PC`=0xF8: addresses 0xF8, 0xFC, 0x00. Assert `rst` during WAIT: all outputs return to their reset values next cycle, and `imem_addr`=0xF8.
